av_pause_menu_ctrl: RTL

- Upstream control stage for the menu overlay renderer; produces the `pause` flag and the menu cursor that the renderer consumes.
- Synchronises and debounces four raw Nexys4 pushbuttons and turns them into press events.
- Runs a play/menu state machine and applies all changes only at the frame boundary (hcount==0, vcount==0), so the overlay never tears mid-frame.
- Issues one-cycle resume/restart/quit pulses to the game core.

---
 rtl/av_pause_menu_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/av_pause_menu_ctrl.sv
// ---------------------------------------------------------------------------
// av_pause_menu_ctrl
//
// Upstream control stage for the menu overlay renderer. Conditions four raw
// pushbuttons into press events, then runs a play/menu state machine. All
// state changes happen only on the frame-boundary cycle (hcount==0 and
// vcount==0), so the overlay never changes mid-frame.
//
// Ports:
//   clk65         65 MHz pixel clock, the only clock
//   reset_n       asynchronous active-low reset
//   hcount        current pixel column from the XVGA timing generator
//   vcount        current pixel row from the XVGA timing generator
//   btn_start     raw pushbutton, asynchronous, active-high
//   btn_up        raw pushbutton, asynchronous, active-high
//   btn_down      raw pushbutton, asynchronous, active-high
//   btn_select    raw pushbutton, asynchronous, active-high
//   pause         1 while the menu is shown
//   menu_sel      highlighted menu item (0 Resume, 1 Restart, 2 Quit)
//   resume_pulse  one-cycle strobe: game continues
//   restart_pulse one-cycle strobe: game restarts
//   quit_pulse    one-cycle strobe: return to song select
// ---------------------------------------------------------------------------
module av_pause_menu_ctrl #(
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int CNT_W           = 20,
  parameter int NUM_ITEMS       = 3
) (
  input  logic        clk65,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        btn_start,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_select,
  output logic        pause,
  output logic [1:0]  menu_sel,
  output logic        resume_pulse,
  output logic        restart_pulse,
  output logic        quit_pulse
);

  // Button indices into the per-button vectors.
  localparam int B_START  = 0;
  localparam int B_UP     = 1;
  localparam int B_DOWN   = 2;
  localparam int B_SELECT = 3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [1:0]       SEL_LAST = 2'(NUM_ITEMS - 1);

  typedef enum logic [0:0] {
    ST_PLAY = 1'b0,
    ST_MENU = 1'b1
  } state_t;

  logic [3:0]       raw_s;
  logic [3:0]       sync1_r;
  logic [3:0]       sync2_r;
  logic [3:0]       deb_r;
  logic [3:0]       press_r;
  logic [3:0]       pend_r;
  logic [CNT_W-1:0] cnt_r [4];
  logic             fb_s;
  logic [1:0]       sel_up_s;
  logic [1:0]       sel_dn_s;
  state_t           state_r;

  assign raw_s = {btn_select, btn_down, btn_up, btn_start};
  assign fb_s  = (hcount == 11'd0) && (vcount == 10'd0);

  // Synchronise and debounce each button; press_r pulses on a debounced 0->1.
  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 4'b0000;
      sync2_r <= 4'b0000;
      deb_r   <= 4'b0000;
      press_r <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= {CNT_W{1'b0}};
      end
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == deb_r[i]) begin
          cnt_r[i]   <= {CNT_W{1'b0}};
          press_r[i] <= 1'b0;
        end else if (cnt_r[i] == CNT_LAST) begin
          // Level has differed long enough: accept it.
          deb_r[i]   <= sync2_r[i];
          cnt_r[i]   <= {CNT_W{1'b0}};
          press_r[i] <= sync2_r[i];
        end else begin
          cnt_r[i]   <= cnt_r[i] + CNT_ONE;
          press_r[i] <= 1'b0;
        end
      end
    end
  end

  // Latch presses until the frame boundary; a press landing on fb is kept.
  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      pend_r <= 4'b0000;
    end else if (fb_s) begin
      pend_r <= press_r;
    end else begin
      pend_r <= pend_r | press_r;
    end
  end

  // Wrapping cursor neighbours for up/down navigation.
  always_comb begin
    sel_up_s = 2'd0;
    sel_dn_s = 2'd0;
    if (menu_sel == 2'd0) begin
      sel_up_s = SEL_LAST;
    end else begin
      sel_up_s = menu_sel - 2'd1;
    end
    if (menu_sel >= SEL_LAST) begin
      sel_dn_s = 2'd0;
    end else begin
      sel_dn_s = menu_sel + 2'd1;
    end
  end

  // Play/menu state machine, acting on pending flags only at frame boundary.
  always_ff @(posedge clk65 or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_PLAY;
      pause         <= 1'b0;
      menu_sel      <= 2'd0;
      resume_pulse  <= 1'b0;
      restart_pulse <= 1'b0;
      quit_pulse    <= 1'b0;
    end else begin
      resume_pulse  <= 1'b0;
      restart_pulse <= 1'b0;
      quit_pulse    <= 1'b0;
      if (fb_s) begin
        case (state_r)
          ST_PLAY: begin
            if (pend_r[B_START]) begin
              state_r  <= ST_MENU;
              pause    <= 1'b1;
              menu_sel <= 2'd0;
            end else begin
              state_r <= ST_PLAY;
            end
          end
          ST_MENU: begin
            if (pend_r[B_SELECT]) begin
              case (menu_sel)
                2'd1:    restart_pulse <= 1'b1;
                2'd2:    quit_pulse    <= 1'b1;
                default: resume_pulse  <= 1'b1;
              endcase
              state_r <= ST_PLAY;
              pause   <= 1'b0;
            end else if (pend_r[B_START]) begin
              resume_pulse <= 1'b1;
              state_r      <= ST_PLAY;
              pause        <= 1'b0;
            end else if (pend_r[B_UP] && !pend_r[B_DOWN]) begin
              menu_sel <= sel_up_s;
            end else if (pend_r[B_DOWN] && !pend_r[B_UP]) begin
              menu_sel <= sel_dn_s;
            end else begin
              menu_sel <= menu_sel;
            end
          end
          default: begin
            state_r <= ST_PLAY;
            pause   <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
